logic_anlz: RTL and testbench
=============================

Name: logic_anlz

Overview:
- 24-channel logic analyzer with run-length compression.
- Samples `up_la_data` every clock while capture is enabled and packs each run of identical samples into one 32-bit word: {count[7:0], value[23:0]}.
- Words are buffered in an internal FIFO and drained over an AXI4-Stream master.
- Configured through an AXI4-Lite slave; raises a high-priority request toward the stream arbiter when the FIFO fills.

Parameters:
- `pADDR_WIDTH`, 15, AXI-Lite address width. Decode uses addr[11:0]; upper bits are ignored.
- `pDATA_WIDTH`, 32, AXI-Lite and stream data width. Fixed at 32.
- `pFIFO_DEPTH`, 256, compressed-word FIFO depth (power of 2). `AW` = log2(`pFIFO_DEPTH`).

Ports:
- `axi_clk` in 1: single clock for all logic.
- `axi_reset` in 1: asynchronous, active-high reset.
- `axi_awvalid` in 1, `axi_awaddr` in `pADDR_WIDTH`, `axi_awready` out 1: AXI-Lite write address.
- `axi_wvalid` in 1, `axi_wdata` in 32, `axi_wstrb` in 4, `axi_wready` out 1: AXI-Lite write data. `axi_wstrb` is ignored; full-word writes only.
- `axi_arvalid` in 1, `axi_araddr` in `pADDR_WIDTH`, `axi_arready` out 1: AXI-Lite read address.
- `axi_rvalid` out 1, `axi_rdata` out 32, `axi_rready` in 1: AXI-Lite read data.
- `cc_la_enable` in 1: system-level LA enable.
- `enable_la` in 1: user-level LA enable.
- `up_la_data` in 24: probed signals.
- `m_tdata` out 32, `m_tvalid` out 1, `m_tready` in 1: compressed stream.
- `m_tstrb` out 4, `m_tkeep` out 4: constant 4'hF.
- `m_tlast` out 1: stream last-word flag.
- `m_tuser` out 2: constant 2'b00.
- `la_hpri_req` out 1: FIFO high-water request.

Behaviour:
- Reset values:
  - Outputs: all ready/valid outputs 0, `axi_rdata` 0, `m_tdata` 0, `la_hpri_req` 0.
  - Registers: `la_mask`=0, `h_thresh`=192, `l_thresh`=64, `pop_cond`=1.
  - FIFO empty, run state idle, overflow flag 0.
- Register map (offset from addr[11:0]):
  - 0x000 `la_mask` [23:0], RW; bits [31:24] read 0.
  - 0x004 `h_thresh` [`AW`:0], RW.
  - 0x008 `l_thresh` [`AW`:0], RW.
  - 0x00C `pop_cond` [`AW`:0], RW.
  - 0x010 status, RO: [`AW`:0] FIFO count, [16] overflow. Any write to 0x010 clears overflow.
  - Other offsets read 0; writes to them are ignored.
- AXI-Lite write:
  - When `axi_awvalid` and `axi_wvalid` are both high and the ready pulse was not issued last cycle, assert `axi_awready` and `axi_wready` together for exactly one cycle.
  - The register updates on that same edge.
- AXI-Lite read:
  - When `axi_arvalid` is high and no read is outstanding, pulse `axi_arready` for one cycle.
  - Next cycle, `axi_rvalid`=1 with `axi_rdata` loaded.
  - `axi_rvalid` and `axi_rdata` hold until `axi_rready` is high; no new read is accepted meanwhile.
- Capture:
  - Capture is active when `cc_la_enable` & `enable_la` & (`la_mask`!=0).
  - Each active cycle, sample s = `up_la_data` & `la_mask`.
  - First active cycle: cur=s, cnt=1, nothing emitted.
  - Subsequent cycles:
    - If s==cur and cnt<255: cnt+1.
    - Otherwise: emit {cnt,cur}, then cur=s, cnt=1.
  - So cnt saturates at 255 and a long run splits into 255-count words.
  - Falling edge of capture-active: emit the pending {cnt,cur} on the next cycle and return to idle.
- FIFO:
  - One emitted word per cycle at most; push and pop may occur in the same cycle.
  - Push while full (and no pop that cycle): the word is dropped and overflow is set (sticky).
- Stream:
  - `m_tvalid`=1 when FIFO is non-empty AND (count>=`pop_cond` OR `la_hpri_req` OR capture inactive).
  - `m_tdata` = FIFO head, stable while `m_tvalid` & !`m_tready`.
  - Pop occurs on `m_tvalid` & `m_tready`.
  - `m_tlast`=1 when the head is the only entry.
- High-priority request, registered with hysteresis:
  - Set when count>=`h_thresh`.
  - Cleared when count<=`l_thresh`.
- An asynchronous reset mid-capture discards the partial run and FIFO contents.

Test Plan:
- Write 0x30001000=0xFFFFFFFF, read it back -> `axi_rdata`=0x00FFFFFF. Write 0x30001004=0x3F, read back -> 0x3F.
- `cc_la_enable`=`enable_la`=1, `la_mask`=all ones, `up_la_data` held at 0x000005 for 3 cycles then 0x000007 for 4 cycles, then disable -> stream emits 0x03000005 then 0x04000007, with `m_tlast` on the last word.
- Constant input for 600 cycles then disable -> words 0xFF......, 0xFF......, 0x5A...... (counts 255, 255, 90).
- `m_tready`=0 with 200 runs of random length 2..63 (values 1..200), then `m_tready`=1 -> the summed run counts equal the cycle totals and the decompressed sequence matches the input exactly.
- `h_thresh`=4, `l_thresh`=1, `m_tready`=0, 5 distinct runs -> `la_hpri_req` rises at count 4; with `m_tready`=1 it stays high until count=1.
- `pFIFO_DEPTH` runs+2 with `m_tready`=0 -> status bit16=1; a write to 0x010 clears it.

Source files
------------

// File: rtl/logic_anlz.sv
// rtl/logic_anlz.sv - 24-channel logic analyzer with run-length compression
// AXI-Lite configured; compressed {count,value} words buffered and drained over an AXI-Stream master.
module logic_anlz #(
  parameter int pADDR_WIDTH = 15,
  parameter int pDATA_WIDTH = 32,
  parameter int pFIFO_DEPTH = 256
) (
  input  logic                   axi_clk,
  input  logic                   axi_reset,
  input  logic                   axi_awvalid,
  input  logic [pADDR_WIDTH-1:0] axi_awaddr,
  output logic                   axi_awready,
  input  logic                   axi_wvalid,
  input  logic [pDATA_WIDTH-1:0] axi_wdata,
  input  logic [3:0]             axi_wstrb,
  output logic                   axi_wready,
  input  logic                   axi_arvalid,
  input  logic [pADDR_WIDTH-1:0] axi_araddr,
  output logic                   axi_arready,
  output logic                   axi_rvalid,
  output logic [pDATA_WIDTH-1:0] axi_rdata,
  input  logic                   axi_rready,
  input  logic                   cc_la_enable,
  input  logic                   enable_la,
  input  logic [23:0]            up_la_data,
  output logic [pDATA_WIDTH-1:0] m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [3:0]             m_tstrb,
  output logic [3:0]             m_tkeep,
  output logic                   m_tlast,
  output logic [1:0]             m_tuser,
  output logic                   la_hpri_req
);

  localparam int AW = $clog2(pFIFO_DEPTH);
  localparam logic [AW:0] LP_FULL = (AW+1)'(pFIFO_DEPTH);

  logic [23:0]            r_la_mask;
  logic [AW:0]            r_h_thresh;
  logic [AW:0]            r_l_thresh;
  logic [AW:0]            r_pop_cond;
  logic                   r_wr_ack;
  logic                   r_ar_ack;
  logic                   r_rvalid;
  logic [11:0]            r_raddr;
  logic [pDATA_WIDTH-1:0] r_rdata;
  logic [pDATA_WIDTH-1:0] w_rd_mux;
  logic                   w_wr_go;
  logic                   w_ovf_clr;

  logic                   r_run;
  logic [23:0]            r_cur;
  logic [7:0]             r_cnt;
  logic                   w_active;
  logic [23:0]            w_sample;
  logic                   w_push;
  logic [31:0]            w_push_data;

  logic [31:0]            r_mem [pFIFO_DEPTH];
  logic [AW-1:0]          r_wptr;
  logic [AW-1:0]          r_rptr;
  logic [AW:0]            r_count;
  logic                   r_ovf;
  logic                   r_hpri;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_wr;
  logic                   w_drop;
  logic                   w_unused_bits;

  assign w_unused_bits = ^{axi_wstrb, axi_awaddr[pADDR_WIDTH-1:12],
                           axi_araddr[pADDR_WIDTH-1:12], axi_wdata[pDATA_WIDTH-1:24]};

  // Write channel: address and data are taken together, one-cycle ready pulse
  assign w_wr_go   = axi_awvalid & axi_wvalid & ~r_wr_ack;
  assign w_ovf_clr = w_wr_go && (axi_awaddr[11:0] == 12'h010);

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      r_wr_ack   <= 1'b0;
      r_la_mask  <= '0;
      r_h_thresh <= (AW+1)'(192);
      r_l_thresh <= (AW+1)'(64);
      r_pop_cond <= (AW+1)'(1);
    end else begin
      r_wr_ack <= w_wr_go;
      if (w_wr_go) begin
        case (axi_awaddr[11:0])
          12'h000: r_la_mask  <= axi_wdata[23:0];
          12'h004: r_h_thresh <= axi_wdata[AW:0];
          12'h008: r_l_thresh <= axi_wdata[AW:0];
          12'h00C: r_pop_cond <= axi_wdata[AW:0];
          default: ;
        endcase
      end
    end
  end

  assign axi_awready = r_wr_ack;
  assign axi_wready  = r_wr_ack;

  always_comb begin
    w_rd_mux = '0;
    case (r_raddr)
      12'h000: w_rd_mux[23:0] = r_la_mask;
      12'h004: w_rd_mux[AW:0] = r_h_thresh;
      12'h008: w_rd_mux[AW:0] = r_l_thresh;
      12'h00C: w_rd_mux[AW:0] = r_pop_cond;
      12'h010: begin
        w_rd_mux[AW:0] = r_count;
        w_rd_mux[16]   = r_ovf;
      end
      default: ;
    endcase
  end

  // Read channel: one outstanding read, data held until the master takes it
  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      r_ar_ack <= 1'b0;
      r_rvalid <= 1'b0;
      r_raddr  <= '0;
      r_rdata  <= '0;
    end else begin
      r_ar_ack <= 1'b0;
      if (axi_arvalid && !r_ar_ack && !r_rvalid) begin
        r_ar_ack <= 1'b1;
        r_raddr  <= axi_araddr[11:0];
      end
      if (r_ar_ack) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_mux;
      end else if (r_rvalid && axi_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign axi_arready = r_ar_ack;
  assign axi_rvalid  = r_rvalid;
  assign axi_rdata   = r_rdata;

  // Run-length encoder: a word leaves when the value changes, the count saturates, or capture stops
  assign w_active    = cc_la_enable & enable_la & (|r_la_mask);
  assign w_sample    = up_la_data & r_la_mask;
  assign w_push_data = {r_cnt, r_cur};

  always_comb begin
    w_push = 1'b0;
    if (r_run) begin
      if (!w_active || (w_sample != r_cur) || (r_cnt == 8'hFF))
        w_push = 1'b1;
    end
  end

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      r_run <= 1'b0;
      r_cur <= '0;
      r_cnt <= '0;
    end else if (w_active) begin
      r_run <= 1'b1;
      if (!r_run || w_push) begin
        r_cur <= w_sample;
        r_cnt <= 8'd1;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end else begin
      r_run <= 1'b0;
    end
  end

  // FIFO: a push into a full FIFO survives only if the head leaves in the same cycle
  assign w_full = (r_count == LP_FULL);
  assign w_pop  = m_tvalid & m_tready;
  assign w_wr   = w_push & (~w_full | w_pop);
  assign w_drop = w_push & w_full & ~w_pop;

  always_ff @(posedge axi_clk) begin
    if (w_wr)
      r_mem[r_wptr] <= w_push_data;
  end

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_hpri  <= 1'b0;
    end else begin
      if (w_wr)
        r_wptr <= r_wptr + AW'(1);
      if (w_pop)
        r_rptr <= r_rptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: ;
      endcase
      if (w_drop)
        r_ovf <= 1'b1;
      else if (w_ovf_clr)
        r_ovf <= 1'b0;
      if (r_count >= r_h_thresh)
        r_hpri <= 1'b1;
      else if (r_count <= r_l_thresh)
        r_hpri <= 1'b0;
    end
  end

  assign m_tvalid    = (r_count != '0) & ((r_count >= r_pop_cond) | r_hpri | ~w_active);
  assign m_tdata     = (r_count != '0) ? r_mem[r_rptr] : '0;
  assign m_tlast     = (r_count == (AW+1)'(1));
  assign m_tstrb     = 4'hF;
  assign m_tkeep     = 4'hF;
  assign m_tuser     = 2'b00;
  assign la_hpri_req = r_hpri;

endmodule

// File: tb/tb_logic_anlz.sv
// tb/tb_logic_anlz.sv - self-checking bench for logic_anlz
// Random and directed capture checked against a run-length reference model.
module tb_logic_anlz;

  logic        axi_clk = 1'b0;
  logic        axi_reset;
  logic        axi_awvalid, axi_wvalid, axi_arvalid, axi_rready;
  logic [14:0] axi_awaddr, axi_araddr;
  logic        axi_awready, axi_wready, axi_arready, axi_rvalid;
  logic [31:0] axi_wdata, axi_rdata;
  logic [3:0]  axi_wstrb;
  logic        cc_la_enable, enable_la;
  logic [23:0] up_la_data;
  logic [31:0] m_tdata;
  logic        m_tvalid, m_tready, m_tlast, la_hpri_req;
  logic [3:0]  m_tstrb, m_tkeep;
  logic [1:0]  m_tuser;

  int n_checks = 0;
  int n_fail   = 0;
  logic [23:0] mask_model;
  logic [23:0] smp_q[$];
  logic [31:0] exp_q[$];
  logic [32:0] got_q[$];

  logic_anlz dut (
    .axi_clk(axi_clk), .axi_reset(axi_reset),
    .axi_awvalid(axi_awvalid), .axi_awaddr(axi_awaddr), .axi_awready(axi_awready),
    .axi_wvalid(axi_wvalid), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wready(axi_wready),
    .axi_arvalid(axi_arvalid), .axi_araddr(axi_araddr), .axi_arready(axi_arready),
    .axi_rvalid(axi_rvalid), .axi_rdata(axi_rdata), .axi_rready(axi_rready),
    .cc_la_enable(cc_la_enable), .enable_la(enable_la), .up_la_data(up_la_data),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tstrb(m_tstrb),
    .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tuser(m_tuser), .la_hpri_req(la_hpri_req)
  );

  always #5 axi_clk = ~axi_clk;

  always @(negedge axi_clk)
    if (m_tvalid && m_tready) got_q.push_back({m_tlast, m_tdata});

  task do_reset;
    axi_reset = 1'b1;
    axi_awvalid = 0; axi_wvalid = 0; axi_arvalid = 0; axi_rready = 0;
    axi_awaddr = '0; axi_araddr = '0; axi_wdata = '0; axi_wstrb = 4'hF;
    cc_la_enable = 0; enable_la = 0; up_la_data = '0; m_tready = 0;
    mask_model = '0;
    repeat (3) @(posedge axi_clk);
    #1 axi_reset = 1'b0;
    got_q.delete(); smp_q.delete(); exp_q.delete();
  endtask

  task axi_write(input logic [31:0] a, input logic [31:0] d);
    int t;
    @(posedge axi_clk); #1;
    axi_awvalid = 1; axi_wvalid = 1; axi_awaddr = a[14:0]; axi_wdata = d;
    t = 0;
    do begin @(negedge axi_clk); t++; end while (!(axi_awready && axi_wready) && t < 20);
    n_checks++;
    if (!(axi_awready && axi_wready)) begin
      n_fail++; $display("FAIL axi_write_ready addr=%h got=0 want=1", a);
    end
    @(posedge axi_clk); #1;
    axi_awvalid = 0; axi_wvalid = 0;
    if (a[11:0] == 12'h000) mask_model = d[23:0];
  endtask

  task axi_read(input logic [31:0] a, output logic [31:0] d);
    int t;
    @(posedge axi_clk); #1;
    axi_arvalid = 1; axi_araddr = a[14:0];
    t = 0;
    do begin @(negedge axi_clk); t++; end while (!axi_arready && t < 20);
    @(posedge axi_clk); #1;
    axi_arvalid = 0;
    n_checks++;
    if (!axi_rvalid) begin
      n_fail++; $display("FAIL axi_read_rvalid addr=%h got=0 want=1", a);
    end
    d = axi_rdata;
    axi_rready = 1;
    @(posedge axi_clk); #1;
    axi_rready = 0;
  endtask

  task drive(input logic [23:0] v, input bit e);
    @(posedge axi_clk); #1;
    up_la_data = v; cc_la_enable = e; enable_la = e;
    if (e && mask_model != 0) smp_q.push_back(v & mask_model);
  endtask

  task drain(input string nm);
    int quiet, t;
    @(posedge axi_clk); #1 m_tready = 1;
    quiet = 0; t = 0;
    while (quiet < 4 && t < 3000) begin
      @(negedge axi_clk); t++;
      if (m_tvalid) quiet = 0; else quiet++;
    end
    n_checks++;
    if (quiet < 4) begin n_fail++; $display("FAIL %s_drain got=busy want=idle", nm); end
    @(posedge axi_clk); #1 m_tready = 0;
  endtask

  // Reference: split the sample history into maximal runs, each chopped into 255-sample pieces
  task build_expected;
    int i, j, len;
    exp_q.delete();
    i = 0;
    while (i < smp_q.size()) begin
      j = i;
      while (j < smp_q.size() && smp_q[j] == smp_q[i]) j++;
      len = j - i;
      while (len > 255) begin exp_q.push_back({8'd255, smp_q[i]}); len -= 255; end
      exp_q.push_back({8'(len), smp_q[i]});
      i = j;
    end
  endtask

  task test_reset;
    logic [31:0] d;
    do_reset();
    n_checks++; if (axi_awready !== 0 || axi_wready !== 0 || axi_arready !== 0 || axi_rvalid !== 0) begin
      n_fail++; $display("FAIL reset_ready got=%b%b%b%b want=0000", axi_awready, axi_wready, axi_arready, axi_rvalid); end
    n_checks++; if (axi_rdata !== 0 || m_tdata !== 0 || m_tvalid !== 0 || la_hpri_req !== 0) begin
      n_fail++; $display("FAIL reset_outputs rdata=%h tdata=%h tvalid=%b hpri=%b want=0", axi_rdata, m_tdata, m_tvalid, la_hpri_req); end
    n_checks++; if (m_tstrb !== 4'hF || m_tkeep !== 4'hF || m_tuser !== 2'b00) begin
      n_fail++; $display("FAIL reset_consts strb=%h keep=%h user=%b", m_tstrb, m_tkeep, m_tuser); end
    axi_read(32'h30001000, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_mask got=%h want=0", d); end
    axi_read(32'h30001004, d);
    n_checks++; if (d !== 32'd192) begin n_fail++; $display("FAIL reset_hthresh got=%0d want=192", d); end
    axi_read(32'h30001008, d);
    n_checks++; if (d !== 32'd64) begin n_fail++; $display("FAIL reset_lthresh got=%0d want=64", d); end
    axi_read(32'h3000100C, d);
    n_checks++; if (d !== 32'd1) begin n_fail++; $display("FAIL reset_popcond got=%0d want=1", d); end
    axi_read(32'h30001010, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_status got=%h want=0", d); end
  endtask

  task test_regs;
    logic [31:0] d;
    do_reset();
    axi_write(32'h30001000, 32'hFFFFFFFF);
    axi_read(32'h30001000, d);
    n_checks++; if (d !== 32'h00FFFFFF) begin n_fail++; $display("FAIL reg_mask got=%h want=00ffffff", d); end
    axi_write(32'h30001004, 32'h3F);
    axi_read(32'h30001004, d);
    n_checks++; if (d !== 32'h3F) begin n_fail++; $display("FAIL reg_hthresh got=%h want=3f", d); end
    axi_write(32'h30001020, 32'h1234);
    axi_read(32'h30001020, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reg_unmapped got=%h want=0", d); end
  endtask

  task test_basic_runs;
    do_reset();
    axi_write(32'h30001000, 32'hFFFFFFFF);
    repeat (3) drive(24'h000005, 1);
    repeat (4) drive(24'h000007, 1);
    drive(24'h000007, 0);
    drain("basic");
    n_checks++; if (got_q.size() != 2) begin n_fail++; $display("FAIL basic_count got=%0d want=2", got_q.size()); end
    else begin
      n_checks++; if (got_q[0] !== {1'b0, 32'h03000005}) begin
        n_fail++; $display("FAIL basic_word0 got=%h want=003000005", got_q[0]); end
      n_checks++; if (got_q[1] !== {1'b1, 32'h04000007}) begin
        n_fail++; $display("FAIL basic_word1 got=%h want=104000007", got_q[1]); end
    end
  endtask

  task test_saturate;
    logic [23:0] v;
    do_reset();
    axi_write(32'h30001000, 32'h00FFFFFF);
    v = 24'($urandom_range(24'hFFFFFF, 1));
    repeat (600) drive(v, 1);
    drive(v, 0);
    drain("saturate");
    n_checks++; if (got_q.size() != 3) begin n_fail++; $display("FAIL sat_count got=%0d want=3", got_q.size()); end
    else begin
      n_checks++; if (got_q[0][31:0] !== {8'hFF, v} || got_q[1][31:0] !== {8'hFF, v} || got_q[2] !== {1'b1, 8'h5A, v}) begin
        n_fail++; $display("FAIL sat_words got=%h,%h,%h want=ff%h,ff%h,5a%h", got_q[0], got_q[1], got_q[2], v, v, v); end
    end
  endtask

  task test_random_backpressure;
    int len, total, bad, sum, k;
    logic [23:0] dec_q[$];
    do_reset();
    axi_write(32'h30001000, 32'hFFFFFFFF);
    total = 0;
    for (int r = 0; r < 200; r++) begin
      len = $urandom_range(63, 2);
      total += len;
      repeat (len) drive(24'(r + 1), 1);
    end
    drive(24'd200, 0);
    build_expected();
    drain("random");
    n_checks++; if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rand_wordcount got=%0d want=%0d", got_q.size(), exp_q.size()); end
    bad = 0; sum = 0;
    for (int i = 0; i < got_q.size(); i++) begin
      if (i >= exp_q.size() || got_q[i][31:0] !== exp_q[i]) bad++;
      sum += int'(got_q[i][31:24]);
      for (k = 0; k < int'(got_q[i][31:24]); k++) dec_q.push_back(got_q[i][23:0]);
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rand_words got=%0d_bad want=0_bad", bad); end
    n_checks++; if (sum != total) begin n_fail++; $display("FAIL rand_sum got=%0d want=%0d", sum, total); end
    bad = 0;
    for (int i = 0; i < smp_q.size(); i++)
      if (i >= dec_q.size() || dec_q[i] !== smp_q[i]) bad++;
    n_checks++; if (bad != 0 || dec_q.size() != smp_q.size()) begin
      n_fail++; $display("FAIL rand_decomp got=%0d_bad len=%0d want=0_bad len=%0d", bad, dec_q.size(), smp_q.size()); end
  endtask

  task test_hpri;
    logic [31:0] d;
    do_reset();
    axi_write(32'h30001004, 32'd4);
    axi_write(32'h30001008, 32'd1);
    axi_write(32'h30001000, 32'hFFFFFF);
    for (int k = 1; k <= 6; k++) begin
      repeat (2) drive(24'(k * 3), 1);
      axi_read(32'h30001010, d);
      n_checks++; if (d[8:0] !== 9'(k - 1)) begin
        n_fail++; $display("FAIL hpri_fill_count k=%0d got=%0d want=%0d", k, d[8:0], k - 1); end
      n_checks++; if (la_hpri_req !== ((k - 1) >= 4)) begin
        n_fail++; $display("FAIL hpri_rise k=%0d got=%b want=%b", k, la_hpri_req, (k - 1) >= 4); end
    end
    for (int p = 1; p <= 4; p++) begin
      @(posedge axi_clk); #1 m_tready = 1;
      @(posedge axi_clk); #1 m_tready = 0;
      repeat (2) @(posedge axi_clk);
      #1;
      n_checks++; if (la_hpri_req !== ((5 - p) > 1)) begin
        n_fail++; $display("FAIL hpri_fall count=%0d got=%b want=%b", 5 - p, la_hpri_req, (5 - p) > 1); end
    end
  endtask

  task test_overflow;
    logic [31:0] d;
    do_reset();
    axi_write(32'h30001000, 32'hFFFFFF);
    for (int i = 1; i <= 256; i++) drive(24'(i), 1);
    axi_read(32'h30001010, d);
    n_checks++; if (d[8:0] !== 9'd255 || d[16] !== 1'b0) begin
      n_fail++; $display("FAIL ovf_prefull got=%h want=000000ff", d); end
    drive(24'd257, 1);
    drive(24'd258, 1);
    drive(24'd258, 0);
    axi_read(32'h30001010, d);
    n_checks++; if (d[8:0] !== 9'd256 || d[16] !== 1'b1) begin
      n_fail++; $display("FAIL ovf_set got=%h want=00010100", d); end
    axi_write(32'h30001010, 32'h0);
    axi_read(32'h30001010, d);
    n_checks++; if (d[16] !== 1'b0 || d[8:0] !== 9'd256) begin
      n_fail++; $display("FAIL ovf_clear got=%h want=00000100", d); end
    drain("overflow");
    n_checks++; if (got_q.size() != 256) begin
      n_fail++; $display("FAIL ovf_drain_count got=%0d want=256", got_q.size()); end
    else begin
      n_checks++; if (got_q[0][31:0] !== 32'h01000001 || got_q[254][31:0] !== 32'h010000FF) begin
        n_fail++; $display("FAIL ovf_words got=%h,%h want=01000001,010000ff", got_q[0], got_q[254]); end
    end
  endtask

  task test_reset_mid_capture;
    logic [31:0] d;
    do_reset();
    axi_write(32'h30001000, 32'hFFFFFF);
    for (int i = 1; i <= 6; i++) drive(24'(i * 7), 1);
    #2 axi_reset = 1'b1;
    #1;
    n_checks++; if (m_tvalid !== 0 || m_tdata !== 0 || la_hpri_req !== 0) begin
      n_fail++; $display("FAIL midreset_outputs tvalid=%b tdata=%h hpri=%b want=0", m_tvalid, m_tdata, la_hpri_req); end
    cc_la_enable = 0; enable_la = 0; mask_model = '0;
    @(posedge axi_clk); #1 axi_reset = 1'b0;
    axi_read(32'h30001010, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL midreset_status got=%h want=0", d); end
    axi_read(32'h30001000, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL midreset_mask got=%h want=0", d); end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_basic_runs();
    test_saturate();
    test_random_backpressure();
    test_hpri();
    test_overflow();
    test_reset_mid_capture();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
